// File: rtl/motor_drive_pwm_if.sv
// motor_drive_pwm_if: command handshake carrying {direction, speed}.
// The commander is the master; the drive block is the slave.
interface motor_drive_pwm_if #(
  parameter int PWM_BITS = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          robot_direction;
  logic [PWM_BITS-1:0] speed;

  modport master (
    output cmd_valid,
    output robot_direction,
    output speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  robot_direction,
    input  speed,
    output cmd_ready
  );
endinterface

// File: rtl/motor_drive_pwm.sv
// motor_drive_pwm: dual L298N driver, ramped PWM with dead time on reversal.
// Define MOTOR_PWM_BRAKE_EN for an active brake during a stop's dead time.
module motor_drive_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 250,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  motor_drive_pwm_if.slave cmd,
  output logic             motor_left_enable,
  output logic             motor_right_enable,
  output logic             motor_left_forward,
  output logic             motor_left_backward,
  output logic             motor_right_forward,
  output logic             motor_right_backward,
  output logic             busy
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W = $clog2(DEAD_PERIODS + 1);
  localparam int DMAX = (2 ** PWM_BITS) - 1;
  localparam int STEP_I = (RAMP_STEP > DMAX) ? DMAX : RAMP_STEP;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(STEP_I);
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEAD_PERIODS);
  localparam logic [DC_W-1:0] DEAD_ONE = DC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RAMP_DOWN,
    DEAD
  } state_t;

  state_t              state;
  logic [PS_W-1:0]     ps_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] cur_duty;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] pend_speed;
  logic [2:0]          cur_dir;
  logic [2:0]          pend_dir;
  logic [DC_W-1:0]     dead_cnt;
  logic [3:0]          pins;

  logic                tick;
  logic                period_end;
  logic                accept;
  logic                drive_on;
  logic                brake_on;
  logic [2:0]          cmd_dir;
  logic [PWM_BITS:0]   diff;
  logic [PWM_BITS-1:0] duty_next;

  // Pin order {left fwd, left bwd, right fwd, right bwd}.
  function automatic logic [3:0] dir_pins(input logic [2:0] d);
    logic [3:0] p;
    p = 4'b0000;
    unique case (1'b1)
      d == 3'd1: p = 4'b1010;
      d == 3'd2: p = 4'b0101;
      d == 3'd3: p = 4'b0110;
      d == 3'd4: p = 4'b1001;
      default:   p = 4'b0000;
    endcase
    return p;
  endfunction

  assign tick       = (ps_cnt == PS_LAST);
  assign period_end = tick && (pwm_cnt == CNT_MAX);
  assign accept     = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_dir    = (cmd.robot_direction > 3'd4) ?
                      3'd0 : cmd.robot_direction;
  assign drive_on   = (state == RUN) || (state == RAMP_DOWN);

`ifdef MOTOR_PWM_BRAKE_EN
  assign brake_on = (state == DEAD) && (pend_dir == 3'd0);
`else
  assign brake_on = 1'b0;
`endif

  always_comb begin
    diff      = '0;
    duty_next = cur_duty;
    if (target > cur_duty) begin
      diff      = {1'b0, target} - {1'b0, cur_duty};
      duty_next = (diff > STEP) ?
                  cur_duty + STEP[PWM_BITS-1:0] : target;
    end else if (target < cur_duty) begin
      diff      = {1'b0, cur_duty} - {1'b0, target};
      duty_next = (diff > STEP) ?
                  cur_duty - STEP[PWM_BITS-1:0] : target;
    end
  end

  assign motor_left_forward   = pins[3];
  assign motor_left_backward  = pins[2];
  assign motor_right_forward  = pins[1];
  assign motor_right_backward = pins[0];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state              <= IDLE;
      ps_cnt             <= '0;
      pwm_cnt            <= '0;
      cur_duty           <= '0;
      target             <= '0;
      pend_speed         <= '0;
      cur_dir            <= '0;
      pend_dir           <= '0;
      dead_cnt           <= '0;
      pins               <= '0;
      motor_left_enable  <= 1'b0;
      motor_right_enable <= 1'b0;
      busy               <= 1'b0;
      cmd.cmd_ready      <= 1'b1;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick)
        pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + 1'b1;
      // Ramp uses the target held before this edge.
      if (period_end)
        cur_duty <= duty_next;
      motor_left_enable  <= (drive_on && (pwm_cnt < cur_duty))
                            || brake_on;
      motor_right_enable <= (drive_on && (pwm_cnt < cur_duty))
                            || brake_on;
      unique case (state)
        IDLE: begin
          if (accept && (cmd_dir != 3'd0)) begin
            pins    <= dir_pins(cmd_dir);
            target  <= cmd.speed;
            cur_dir <= cmd_dir;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (cmd_dir == cur_dir) begin
              target <= cmd.speed;
            end else begin
              pend_dir      <= cmd_dir;
              pend_speed    <= cmd.speed;
              target        <= '0;
              busy          <= 1'b1;
              cmd.cmd_ready <= 1'b0;
              state         <= RAMP_DOWN;
            end
          end
        end
        RAMP_DOWN: begin
          if (period_end && (duty_next == '0)) begin
`ifdef MOTOR_PWM_BRAKE_EN
            pins <= (pend_dir == 3'd0) ? 4'b1111 : 4'b0000;
`else
            pins <= 4'b0000;
`endif
            dead_cnt <= DEAD_LOAD;
            state    <= DEAD;
          end
        end
        DEAD: begin
          if (period_end) begin
            if (dead_cnt == DEAD_ONE) begin
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b1;
              dead_cnt      <= '0;
              if (pend_dir == 3'd0) begin
                pins  <= 4'b0000;
                state <= IDLE;
              end else begin
                pins    <= dir_pins(pend_dir);
                target  <= pend_speed;
                cur_dir <= pend_dir;
                state   <= RUN;
              end
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
